// File: rtl/dump_pkg.sv
// Shared types and constants for the RAM dump reader and its RAM-side neighbours.
// The RAM encodings must match what the RAM and the MEM-stage control use.
package dump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_e;

  localparam int unsigned WORD_STEP = 4;
  localparam int unsigned MAX_WORDS = 64;

  localparam logic RW_READ   = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

endpackage

// File: rtl/ram_dump_reader.sv
// Walks a word-aligned RAM range after a start pulse and streams each 32-bit word
// with its byte address over valid/ready; read-only, two cycles per word.
module ram_dump_reader
  import dump_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 7
) (
  input  logic              clk,
  input  logic              R,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              mem_E,
  output logic              mem_RW,
  output logic              mem_Size,
  output logic [ADDR_W-1:0] mem_A,
  input  logic [DATA_W-1:0] mem_DO,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_out_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [CNT_W-1:0]  count_clamped;
  logic              last_word;

  assign count_clamped = (word_count > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : word_count;
  assign last_word     = (remaining_q == CNT_W'(1));

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (count_clamped == '0) ? DONE : READ;
        end
      end
      READ: state_d = SEND;
      SEND: begin
        if (out_ready) begin
          state_d = last_word ? DONE : READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_E     = 1'b0;
    mem_RW    = RW_READ;
    mem_Size  = 1'b0;
    mem_A     = '0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = (state_q != IDLE);
    unique case (state_q)
      READ: begin
        mem_E    = 1'b1;
        mem_Size = SIZE_WORD;
        mem_A    = addr_q;
      end
      SEND:    out_valid = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Address wraps naturally at the top of the RAM through the ADDR_W-bit add.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      addr_q      <= '0;
      addr_out_q  <= '0;
      data_q      <= '0;
      remaining_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && (count_clamped != '0)) begin
            addr_q      <= {base_addr[ADDR_W-1:2], 2'b00};
            remaining_q <= count_clamped;
          end
        end
        READ: begin
          data_q     <= mem_DO;
          addr_out_q <= addr_q;
        end
        SEND: begin
          if (out_ready) begin
            remaining_q <= remaining_q - CNT_W'(1);
            if (!last_word) begin
              addr_q <= addr_q + ADDR_W'(WORD_STEP);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = data_q;
  assign out_addr = addr_out_q;

endmodule

// File: tb/tb_ram_dump_reader.sv
// Directed bench for ram_dump_reader with a byte-wide 256-entry RAM model
// (big-endian word reads) and a stream monitor.
module tb_ram_dump_reader;

  logic        clk = 1'b0;
  logic        R;
  logic        start;
  logic [7:0]  base_addr;
  logic [6:0]  word_count;
  logic        mem_E, mem_RW, mem_Size;
  logic [7:0]  mem_A;
  logic [31:0] mem_DO;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_addr;
  logic        busy, done;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  ram [256];
  logic [7:0]  seen_addr [$];
  logic [31:0] seen_data [$];
  int          busy_cycles, done_count, cyc, last_hs_cyc, done_cyc;
  logic        timed_out;

  ram_dump_reader dut (
    .clk       (clk),
    .R         (R),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .mem_E     (mem_E),
    .mem_RW    (mem_RW),
    .mem_Size  (mem_Size),
    .mem_A     (mem_A),
    .mem_DO    (mem_DO),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  assign mem_DO = {ram[mem_A], ram[8'(mem_A + 8'd1)], ram[8'(mem_A + 8'd2)],
                   ram[8'(mem_A + 8'd3)]};

  // Monitor samples on the falling edge; stimulus changes 1 time unit after the rising edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) begin
      seen_addr.push_back(out_addr);
      seen_data.push_back(out_data);
      last_hs_cyc <= cyc;
    end
    if (busy) busy_cycles <= busy_cycles + 1;
    if (done) begin
      done_count <= done_count + 1;
      done_cyc   <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    seen_addr.delete();
    seen_data.delete();
    busy_cycles = 0;
    done_count  = 0;
    last_hs_cyc = -100;
    done_cyc    = -200;
  endtask

  task automatic start_dump(input logic [7:0] base, input logic [6:0] cnt);
    @(posedge clk); #1;
    clear_stats();
    start      = 1'b1;
    base_addr  = base;
    word_count = cnt;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_count > 0 && !busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    check({tag, "_timeout"}, {31'd0, timed_out}, 32'd0);
  endtask

  task automatic check_word(input string tag, input int idx, input logic [7:0] a,
                            input logic [31:0] d);
    if (idx < seen_addr.size()) begin
      check({tag, "_addr"}, {24'd0, seen_addr[idx]}, {24'd0, a});
      check({tag, "_data"}, seen_data[idx], d);
    end else begin
      check({tag, "_present"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    for (int i = 0; i < 8; i++) ram[i] = 8'(8'h11 * (i + 1));
    cyc = 0;
    clear_stats();
    R = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mem", {21'd0, mem_E, mem_Size, mem_RW, mem_A}, 32'd0);
    check("rst_out", {out_data[23:0], out_addr}, 32'd0);
    @(posedge clk); #2;
    R = 1'b0;

    // Basic dump, no backpressure
    start_dump(8'h00, 7'd2);
    check("basic_read_memE", {31'd0, mem_E}, 32'd1);
    check("basic_read_size", {31'd0, mem_Size}, 32'd1);
    check("basic_read_rw", {31'd0, mem_RW}, 32'd0);
    wait_idle("basic", 20);
    check("basic_words", seen_addr.size(), 32'd2);
    check_word("basic_w0", 0, 8'h00, 32'h11223344);
    check_word("basic_w1", 1, 8'h04, 32'h55667788);
    check("basic_busy_cycles", busy_cycles, 32'd5);
    check("basic_done_count", done_count, 32'd1);
    check("basic_done_latency", done_cyc - last_hs_cyc, 32'd1);

    // Backpressure during first SEND
    out_ready = 1'b0;
    start_dump(8'h00, 7'd2);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data", out_data, 32'h11223344);
      check("bp_addr", {24'd0, out_addr}, 32'd0);
      check("bp_memE", {31'd0, mem_E}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle("bp", 20);
    check("bp_words", seen_addr.size(), 32'd2);
    check_word("bp_w1", 1, 8'h04, 32'h55667788);
    check("bp_busy_cycles", busy_cycles, 32'd8);

    // Wrap and alignment
    start_dump(8'hFE, 7'd3);
    wait_idle("wrap", 20);
    check("wrap_words", seen_addr.size(), 32'd3);
    check_word("wrap_w0", 0, 8'hFC, 32'hFCFDFEFF);
    check_word("wrap_w1", 1, 8'h00, 32'h11223344);
    check_word("wrap_w2", 2, 8'h04, 32'h55667788);

    // Zero count
    start_dump(8'h10, 7'd0);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd1);
    wait_idle("zero", 10);
    check("zero_words", seen_addr.size(), 32'd0);
    check("zero_busy_cycles", busy_cycles, 32'd1);

    // Clamp to 64 words
    start_dump(8'h00, 7'd100);
    wait_idle("clamp", 300);
    check("clamp_words", seen_addr.size(), 32'd64);
    check_word("clamp_w63", 63, 8'hFC, 32'hFCFDFEFF);
    check("clamp_busy_cycles", busy_cycles, 32'd129);

    // Reset asserted while a word waits in SEND
    out_ready = 1'b0;
    start_dump(8'h10, 7'd4);
    @(posedge clk); #1;
    check("mid_in_send", {31'd0, out_valid}, 32'd1);
    #2 R = 1'b1;
    #1;
    check("mid_valid", {31'd0, out_valid}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_done", {31'd0, done}, 32'd0);
    check("mid_out", out_data, 32'd0);
    check("mid_mem", {23'd0, mem_E, mem_A}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    R = 1'b0;
    out_ready = 1'b1;
    check("mid_no_done", done_count, 32'd0);
    check("mid_no_words", seen_addr.size(), 32'd0);
    start_dump(8'h20, 7'd1);
    wait_idle("mid_restart", 20);
    check("mid_restart_words", seen_addr.size(), 32'd1);
    check_word("mid_restart_w0", 0, 8'h20, 32'h20212223);

    // Start pulses while busy are ignored
    start_dump(8'h00, 7'd2);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h40; word_count = 7'd2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("busy_start", 20);
    repeat (4) @(posedge clk);
    #1;
    check("busy_start_idle", {31'd0, busy}, 32'd0);
    check("busy_start_words", seen_addr.size(), 32'd2);
    check_word("busy_start_w0", 0, 8'h00, 32'h11223344);
    check_word("busy_start_w1", 1, 8'h04, 32'h55667788);
    check("busy_start_done", done_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_dump_reader.md
# ram_dump_reader

Sequential read-back engine for the 256x8 data RAM, the counterpart to the program/data loader that fills memory. After a start pulse it walks a word-aligned address range, reads one 32-bit word per step through the RAM's combinational read port, and emits each word with its address on a valid/ready stream. Memory state can then be logged or compared after the pipeline halts. It sits beside the MEM stage; the top level muxes the RAM port to this block while `busy` is high.

## Interface
Parameters:
- `ADDR_W`, 8: RAM address width.
- `DATA_W`, 32: word width returned by the RAM in word mode.
- `CNT_W`, 7: width of the word-count input; max count is 64.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `R`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first byte address; bits [1:0] are forced to 0 at latch.
- `word_count`  in  CNT_W  number of words to dump, 0..64. Values above 64 are clamped to 64.
- `mem_E`  out  1  RAM enable.
- `mem_RW`  out  1  RAM direction; 0 = read. Always 0 from this block.
- `mem_Size`  out  1  1 = word access.
- `mem_A`  out  ADDR_W  RAM address.
- `mem_DO`  in  DATA_W  RAM read data, combinational from `mem_A`.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  DATA_W  captured word.
- `out_addr`  out  ADDR_W  byte address of `out_data`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of dump.

## Operation
- State machine with four states: IDLE, READ, SEND, DONE.
- IDLE
  - On `start` with a clamped count != 0: latch `addr = {base_addr[7:2],2'b00}`, latch `remaining = count`, go to READ.
  - On `start` with count == 0: go to DONE (no words emitted).
- READ
  - Drive `mem_E=1`, `mem_Size=1`, `mem_RW=0`, `mem_A=addr`.
  - On the edge: `data_reg <= mem_DO`, `addr_reg <= addr`, go to SEND.
- SEND
  - `out_valid=1`, with `out_data=data_reg` and `out_addr=addr_reg`.
  - On `out_ready`: `remaining <= remaining-1`.
    - If `remaining==1`, go to DONE.
    - Otherwise `addr <= addr+4` (mod 256, wraps 0xFC -> 0x00) and go to READ.
  - Without `out_ready`: hold. `out_data` and `out_addr` stay stable and `out_valid` stays high.
- DONE
  - `done=1` for exactly one cycle, then IDLE.
- `start` is ignored in READ, SEND and DONE.
- RAM outputs when not in READ: `mem_E=0`, `mem_A=0`, `mem_Size=0`, `mem_RW=0`.
- The block never writes RAM.

## Timing
- Reset values:
  - state = IDLE.
  - Registers: `addr`, `addr_reg`, `data_reg` = 0; `remaining` = 0.
  - Outputs: `out_valid`, `busy`, `done`, `mem_E`, `mem_Size`, `mem_RW` = 0; `mem_A`, `out_data`, `out_addr` = 0.
- Reset asserted mid-dump:
  - Immediate abort to IDLE, with no `done` pulse.
  - A word pending in SEND is dropped.
- Start-to-stream latency:
  - `start` sampled at edge N, READ in cycle N+1.
  - First `out_valid` in cycle N+2.
- Throughput: 2 cycles per word when `out_ready` is held high. An N-word dump with no backpressure has `busy` high for 2N+1 cycles (READ/SEND x N, plus DONE).
- `done` asserts the cycle after the last handshake. `busy` falls together with `done` returning low.
- Count 0: `busy` and `done` are high for one cycle, starting the cycle after `start`.
- Outputs `out_*`, `busy` and `done` are decoded from registered state only. `mem_*` is decoded from state and `addr`. There is no combinational path from `out_ready` to any output.

## Structure
- Shared package `dump_pkg`:
  - State enum: IDLE=2'd0, READ=2'd1, SEND=2'd2, DONE=2'd3.
  - Constants `WORD_STEP=4` and `MAX_WORDS=64`.
  - RAM encodings `RW_READ=1'b0` and `SIZE_WORD=1'b1`, shared with the RAM and the MEM-stage control.
- Single module, no sub-module.
- The top-level RAM-port mux, selected by `busy`, lives outside this block.

## Test plan
- Basic dump:
  - Preload RAM[0..7] = 0x11..0x88. Drive `start`, `base=0x00`, `count=2`, `ready=1`.
  - Expect two words: (0x00, 0x11223344 in the RAM's byte order) and (0x04, 0x55667788).
  - Expect `done` 1 cycle after the second handshake and `busy` high for 5 cycles.
- Backpressure:
  - Same setup, hold `ready=0` for 3 cycles during the first SEND.
  - `out_data` and `out_addr` stay stable, `out_valid` stays high, `mem_E=0` throughout.
  - Then `ready=1`: normal completion.
- Wrap and alignment:
  - `base=0xFE`, `count=3`.
  - Expected `out_addr` sequence is 0xFC, 0x00, 0x04.
- Zero and clamp:
  - `count=0`: no `out_valid`, `done` the cycle after `start`.
  - `count=100`: exactly 64 words emitted.
- Reset mid-dump:
  - Assert `R` asynchronously while in SEND during a 4-word dump.
  - All outputs go to 0 immediately, with no `done`.
  - After release, a fresh `start` dumps correctly from its own base.
- Start while busy:
  - Pulse `start` with `base=0x40` during a running dump from 0x00.
  - The running dump is unchanged and no second dump begins.
